// File: rtl/weight_fetch_pkg.sv
// weight_fetch_pkg: shared constants and FSM state type for the weight fetcher.
package weight_fetch_pkg;
  localparam int ADDR_W = 18;
  localparam int ADDR_LIMIT_DEF = 196608;
  typedef enum logic [2:0] {IDLE, CHECK, FETCH, DRAIN, FIN} state_t;
endpackage

// File: rtl/weight_fifo.sv
// weight_fifo: synchronous FIFO with occupancy count; tolerates push and pop in one cycle.
module weight_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign rd = pop && !empty;
  assign wr = push && (count != CW'(DEPTH) || rd);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/weight_fetcher.sv
// weight_fetcher: streams a range of weight-SRAM words into a credit-limited FIFO toward the array.
module weight_fetcher
  import weight_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [15:0]       w_data,
  output logic              w_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr, rem;
  logic inflight, inflight_last, bad, issue, range_bad, empty;
  logic [CW-1:0] count;
  logic [16:0] head;
  logic unused_hi;
  assign unused_hi = ^sram_rdata[31:16];
  assign range_bad = {1'b0, addr} + {1'b0, rem} > (ADDR_W+1)'(ADDR_LIMIT);
  // words buffered plus the one read still on the SRAM bus must leave room
  assign issue = state == FETCH && (32'(count) + 32'(inflight) < 32'(FIFO_DEPTH));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? CHECK : IDLE;
      CHECK: state_nx = (rem == '0 || range_bad) ? FIN : FETCH;
      FETCH: state_nx = (issue && rem == ADDR_W'(1)) ? DRAIN : FETCH;
      DRAIN: state_nx = (empty && !inflight) ? FIN : DRAIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      bad <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= issue;
      inflight_last <= issue && rem == ADDR_W'(1);
      if (state == IDLE && start) begin
        addr <= base_addr;
        rem <= length;
      end else if (issue) begin
        addr <= addr + ADDR_W'(1);
        rem <= rem - ADDR_W'(1);
      end
      if (state == CHECK) bad <= rem != '0 && range_bad;
    end
  weight_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(17)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight),
    .din({inflight_last, sram_rdata[15:0]}),
    .pop(w_ready),
    .dout(head),
    .empty(empty),
    .count(count)
  );
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign err = done && bad;
  assign sram_cs = issue;
  assign sram_oe = inflight;
  assign sram_web = 1'b1;
  assign sram_addr = issue ? addr : '0;
  assign w_valid = !empty;
  assign w_data = empty ? 16'h0 : head[15:0];
  assign w_last = !empty && head[16];
endmodule

// File: tb/tb_weight_fetcher.sv
// tb_weight_fetcher: randomized scoreboard bench with a word-level model of fetch jobs.
module tb_weight_fetcher;
  localparam int LIMIT = 196608;
  typedef struct {logic err; int lat;} job_t;
  logic clk, rst_n, start, busy, done, err, sram_cs, sram_oe, sram_web, w_valid, w_ready, w_last;
  logic [17:0] base_addr, length, sram_addr;
  logic [31:0] sram_rdata;
  logic [15:0] w_data, rd_w;
  weight_fetcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err), .sram_cs(sram_cs), .sram_oe(sram_oe),
    .sram_web(sram_web), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] mem_word(input logic [17:0] a);
    logic [31:0] x;
    x = {14'b0, a} * 32'd40503 + 32'd7;
    return x[15:0] ^ x[31:16];
  endfunction
  assign rd_w = mem_word(sram_addr);
  always @(posedge clk) sram_rdata <= sram_cs ? {{16{rd_w[15]}}, rd_w} : $urandom;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, fails = 0;
  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  logic [16:0] exp_w[$];
  logic [17:0] exp_a[$];
  job_t exp_j[$];
  int mode = 0, pat_i = 0, start_cyc = 0;
  bit gapless = 0;
  always @(posedge clk) begin
    #1;
    pat_i++;
    w_ready = mode == 0 ? 1'b1 : mode == 1 ? (pat_i % 4 == 0 || pat_i % 4 == 3) : ($urandom_range(0, 3) != 0);
  end
  int issued = 0, transfers = 0, last_cs = 0, last_w = 0;
  bit seen_cs = 0, seen_w = 0, prev_cs = 0, hold_prev = 0;
  logic [16:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      check(!busy && !done && !err && !sram_cs && !sram_oe && !w_valid && !w_last, "reset flags",
            {busy, done, err, sram_cs, sram_oe, w_valid, w_last}, 0);
      check(sram_web && sram_addr == 0 && w_data == 0, "reset buses", {sram_web, sram_addr, w_data}, 35'h4_0000_0000);
      exp_w.delete(); exp_a.delete(); exp_j.delete();
      issued = transfers; seen_cs = 0; seen_w = 0; prev_cs = 0; hold_prev = 0;
    end else begin
      check(sram_oe == prev_cs, "sram_oe", sram_oe, prev_cs);
      check(sram_web == 1'b1, "sram_web", sram_web, 1);
      prev_cs = sram_cs;
      if (sram_cs) begin
        if (exp_a.size() == 0) check(0, "unexpected sram_cs", sram_addr, 0);
        else begin
          automatic logic [17:0] a = exp_a.pop_front();
          check(sram_addr == a, "sram_addr", sram_addr, a);
        end
        check(issued - transfers < 4, "credit", issued - transfers, 4);
        if (gapless && seen_cs) check(cyc == last_cs + 1, "issue gap", cyc, last_cs + 1);
        seen_cs = 1; last_cs = cyc; issued++;
      end
      if (hold_prev) check(w_valid && {w_last, w_data} == held, "stall hold", {w_valid, w_last, w_data}, {1'b1, held});
      hold_prev = w_valid && !w_ready;
      held = {w_last, w_data};
      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) check(0, "unexpected word", {w_last, w_data}, 0);
        else begin
          automatic logic [16:0] e = exp_w.pop_front();
          check({w_last, w_data} == e, "word", {w_last, w_data}, e);
        end
        if (gapless && seen_w) check(cyc == last_w + 1, "word gap", cyc, last_w + 1);
        seen_w = 1; last_w = cyc; transfers++;
      end
      if (done) begin
        if (exp_j.size() == 0) check(0, "unexpected done", done, 0);
        else begin
          automatic job_t j = exp_j.pop_front();
          check(err == j.err, "err", err, j.err);
          if (j.lat >= 0) check(cyc - start_cyc == j.lat, "reject latency", cyc - start_cyc, j.lat);
          check(exp_w.size() == 0 && exp_a.size() == 0, "done early", exp_w.size(), 0);
        end
        seen_cs = 0; seen_w = 0;
      end else if (err) check(0, "err without done", err, 0);
    end
  end
  task automatic pulse(input logic [17:0] b, input logic [17:0] l);
    @(posedge clk);
    #1 base_addr = b; length = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin @(posedge clk); n++; end
    if (busy) check(0, "idle timeout", n, 3000);
  endtask
  task automatic wait_done();
    int n = 0;
    while (exp_j.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (exp_j.size() != 0) check(0, "done timeout", n, 3000);
  endtask
  task automatic start_job(input logic [17:0] b, input logic [17:0] l);
    automatic bit rej = l == 0 || int'(b) + int'(l) > LIMIT;
    automatic job_t j;
    wait_idle();
    @(posedge clk);
    #1 base_addr = b; length = l; start = 1'b1; start_cyc = cyc;
    j.err = l != 0 && rej;
    j.lat = rej ? 2 : -1;
    if (!rej)
      for (int i = 0; i < int'(l); i++) begin
        exp_a.push_back(b + 18'(i));
        exp_w.push_back({i == int'(l) - 1, mem_word(b + 18'(i))});
      end
    exp_j.push_back(j);
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic run_job(input logic [17:0] b, input logic [17:0] l, input bit g);
    gapless = g;
    start_job(b, l);
    wait_done();
    gapless = 0;
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; w_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(18'h00010, 8, 1);
    run_job(18'h07FFE, 4, 1);
    mode = 1;
    run_job(18'h01234, 16, 0);
    mode = 0;
    run_job(18'h2FFFF, 2, 0);
    run_job(18'h00005, 0, 0);
    run_job(18'(LIMIT - 8), 8, 1);
    run_job(18'(LIMIT - 7), 8, 0);
    mode = 2;
    start_job(18'h00100, 10);
    begin
      automatic int t0 = transfers, n = 0;
      while (transfers - t0 < 3 && n < 500) begin @(negedge clk); n++; end
      if (transfers - t0 < 3) check(0, "reset wait timeout", transfers - t0, 3);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    mode = 0;
    run_job(18'h00300, 6, 1);
    start_job(18'h00200, 12);
    repeat (4) @(posedge clk);
    pulse(18'h00000, 18'h3);
    wait_done();
    mode = 2;
    for (int k = 0; k < 10; k++) begin
      automatic logic [17:0] b = $urandom_range(0, 1) ? 18'($urandom_range(LIMIT - 30, LIMIT - 1)) : 18'($urandom_range(0, 4000));
      run_job(b, 18'($urandom_range(0, 20)), 0);
    end
    wait_idle();
    repeat (4) @(posedge clk);
    check(exp_w.size() == 0 && exp_a.size() == 0 && exp_j.size() == 0, "queues drained",
          exp_w.size() + exp_a.size() + exp_j.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/weight_fetcher.md
WEIGHT_FETCHER -- requirements
Module: weight_fetcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: output buffer depth in 16-bit words; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_LIMIT, default 196608: number of valid weight-SRAM words (6 x 32768).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; accepted only in IDLE.
REQ-006 base_addr  input  18  first word address; sampled on an accepted start.
REQ-007 length  input  18  word count; sampled on an accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when a job completes.
REQ-010 err  output  1  one-cycle pulse, coincident with done, when a job is rejected for range.
REQ-011 sram_cs  output  1  weight-SRAM chip select for the read issued this cycle.
REQ-012 sram_oe  output  1  weight-SRAM output enable; high in the cycle after each issue.
REQ-013 sram_web  output  1  write-enable-bar; tied to 1, because this block only reads.
REQ-014 sram_addr  output  18  weight-SRAM word address.
REQ-015 sram_rdata  input  32  sign-extended read data; only bits [15:0] are consumed.
REQ-016 w_valid / w_ready  output / input  1 / 1  weight-stream handshake toward the array.
REQ-017 w_data  output  16  weight word.
REQ-018 w_last  output  1  high with the final word of a job.

Function
REQ-019 The FSM SHALL have states IDLE, CHECK, FETCH, DRAIN and FIN.
- IDLE -> CHECK on start.
- CHECK -> FIN when length == 0 or base_addr + length > ADDR_LIMIT (19-bit compare).
- CHECK -> FETCH otherwise.
REQ-020 In CHECK with an out-of-range job, done and err SHALL be asserted in FIN and no SRAM access SHALL occur; length == 0 raises done only.
REQ-021 In FETCH, a read SHALL issue (sram_cs=1, sram_addr=next address) only when fifo_count + inflight < FIFO_DEPTH.
REQ-022 Read data SHALL be captured into the FIFO exactly one cycle after issue, with sram_oe=1 during that capture cycle.
REQ-023 Addresses SHALL increment by 1 per issue, from base_addr to base_addr + length - 1.
REQ-024 The FSM SHALL go FETCH -> DRAIN after the last issue, and DRAIN -> FIN when the FIFO is empty and inflight == 0.
REQ-025 FIN SHALL last one cycle, pulse done, and return to IDLE.
REQ-026 Stream rules:
- w_data and w_valid come from the FIFO head.
- A word transfers on w_valid && w_ready.
- w_valid, w_data and w_last SHALL stay stable while w_valid && !w_ready.
REQ-027 w_last SHALL mark the word whose stream index equals length - 1.
REQ-028 The FIFO SHALL handle a push and a pop in the same cycle with no change in count and no data loss.
REQ-029 The FIFO SHALL never overflow, guaranteed by the REQ-021 credit rule; sustained throughput SHALL be 1 word/cycle while w_ready=1.
REQ-030 start SHALL be ignored while busy.
REQ-031 sram_cs SHALL be 0 in IDLE, CHECK, DRAIN and FIN.

Reset
REQ-032 On rst_n low, the block SHALL asynchronously clear to:
- state IDLE, FIFO empty, inflight 0;
- busy, done, err, sram_cs, sram_oe, w_valid, w_last = 0;
- sram_web = 1; sram_addr, w_data = 0.
REQ-033 A reset asserted mid-job SHALL abort the job; after release no done pulse is produced and the block waits for a fresh start.

Structure
REQ-034 ADDR_LIMIT default, the state enum and the address width constant (18) SHALL reside in shared package weight_fetch_pkg.
REQ-035 The FIFO SHALL be a separate sub-module, weight_fifo: synchronous, parameterised depth and width, with count output.

Verification
REQ-036 base=0x00010, length=8, w_ready=1 -> addresses 0x10..0x17 issued on consecutive cycles; 8 words out in order; w_last on word 7; one done pulse.
REQ-037 base=0x07FFE, length=4 (crosses the 32768-word bank boundary) -> words from 0x7FFE, 0x7FFF, 0x8000, 0x8001 delivered in order, with no gap.
REQ-038 length=16 with w_ready toggling 1,0,0,1 -> sram_cs stalls whenever 4 words are buffered or in flight; no word is lost or duplicated; w_data is held stable during stalls.
REQ-039 base=0x2FFFF, length=2 -> no sram_cs at all; done and err pulse together 2 cycles after start; length=0 -> done only.
REQ-040 rst_n dropped after 3 of 10 words transfer -> all outputs at reset values immediately; no done after release; a new start runs normally.
REQ-041 start pulsed while busy -> ignored; the current job's words and done pulse are unaffected.
